// File: rtl/regfile_mp.sv
// Multi-port register file: hard zero, GP registers, SP, PC, flags and a pending scoreboard.
// Two registered read ports with optional write forwarding; wr2 beats wr1 on a collision.
module regfile_mp #(
    parameter int                DATA_W   = 16,
    parameter int                NUM_GP   = 8,
    parameter int                FLAG_W   = 8,
    parameter bit                BYPASS   = 1'b1,
    parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(1),
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] RESET_SP = '0,
    localparam int               IDX_W    = $clog2(NUM_GP + 3)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd1_num,
    input  logic [IDX_W-1:0]  rd2_num,
    output logic [DATA_W-1:0] rd1_value,
    output logic [DATA_W-1:0] rd2_value,
    output logic              rd1_pending,
    output logic              rd2_pending,
    input  logic              wr1_en,
    input  logic              wr2_en,
    input  logic [IDX_W-1:0]  wr1_num,
    input  logic [IDX_W-1:0]  wr2_num,
    input  logic [DATA_W-1:0] wr1_value,
    input  logic [DATA_W-1:0] wr2_value,
    input  logic              fetch_we,
    input  logic [DATA_W-1:0] fetch_value,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc_value,
    input  logic              sp_push,
    input  logic              sp_pop,
    input  logic [FLAG_W-1:0] flags_we,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [FLAG_W-1:0] flags_out,
    input  logic              reserve_en,
    input  logic [IDX_W-1:0]  reserve_num
);

    localparam int               NUM_SLOT = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] SP_NUM   = IDX_W'(NUM_GP + 1);
    localparam logic [IDX_W-1:0] PC_NUM   = IDX_W'(NUM_GP + 2);

    logic [DATA_W-1:0] gp_q [NUM_GP];
    logic [DATA_W-1:0] gp_d [NUM_GP];
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [NUM_SLOT-1:0] pend_q, pend_d;
    logic [NUM_SLOT-1:0] pend_view;
    logic [DATA_W-1:0] rd_view [NUM_SLOT];

    logic [DATA_W-1:0] rd1_value_q, rd1_value_d;
    logic [DATA_W-1:0] rd2_value_q, rd2_value_d;
    logic              rd1_pending_q, rd1_pending_d;
    logic              rd2_pending_q, rd2_pending_d;

    logic wr1_hit, wr2_hit;

    function automatic logic is_mapped(input logic [IDX_W-1:0] num);
        return (num != '0) && (num <= PC_NUM);
    endfunction

    assign wr1_hit = wr1_en && is_mapped(wr1_num);
    assign wr2_hit = wr2_en && is_mapped(wr2_num);

    always_comb begin
        gp_d = gp_q;
        for (int i = 0; i < NUM_GP; i++) begin
            if (wr2_hit && (wr2_num == IDX_W'(i + 1))) begin
                gp_d[i] = wr2_value;
            end else if (wr1_hit && (wr1_num == IDX_W'(i + 1))) begin
                gp_d[i] = wr1_value;
            end
        end
    end

    // Push and pop together cancel out and the SP holds.
    always_comb begin
        sp_d = sp_q;
        if (wr2_hit && (wr2_num == SP_NUM)) begin
            sp_d = wr2_value;
        end else if (wr1_hit && (wr1_num == SP_NUM)) begin
            sp_d = wr1_value;
        end else if (sp_push && !sp_pop) begin
            sp_d = sp_q - DATA_W'(1);
        end else if (sp_pop && !sp_push) begin
            sp_d = sp_q + DATA_W'(1);
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (wr2_hit && (wr2_num == PC_NUM)) begin
            pc_d = wr2_value;
        end else if (wr1_hit && (wr1_num == PC_NUM)) begin
            pc_d = wr1_value;
        end else if (fetch_we) begin
            pc_d = fetch_value;
        end else if (pc_inc) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    assign flags_d = (flags_q & ~flags_we) | (flags_in & flags_we);

    // A reserve in the same cycle as a write leaves the bit set: the new producer wins.
    always_comb begin
        pend_d = '0;
        for (int r = 1; r <= NUM_GP + 2; r++) begin
            if (reserve_en && (reserve_num == IDX_W'(r))) begin
                pend_d[r] = 1'b1;
            end else if ((wr1_hit && (wr1_num == IDX_W'(r))) ||
                         (wr2_hit && (wr2_num == IDX_W'(r)))) begin
                pend_d[r] = 1'b0;
            end else begin
                pend_d[r] = pend_q[r];
            end
        end
    end

    // Unmapped slots and slot 0 stay zero in the read view.
    always_comb begin
        for (int s = 0; s < NUM_SLOT; s++) begin
            rd_view[s] = '0;
        end
        for (int i = 0; i < NUM_GP; i++) begin
            rd_view[i + 1] = gp_q[i];
        end
        rd_view[SP_NUM] = sp_q;
        rd_view[PC_NUM] = pc_q;
        if (BYPASS) begin
            if (wr1_hit) begin
                rd_view[wr1_num] = wr1_value;
            end
            if (wr2_hit) begin
                rd_view[wr2_num] = wr2_value;
            end
        end
    end

    assign pend_view     = BYPASS ? pend_d : pend_q;
    assign rd1_value_d   = rd_view[rd1_num];
    assign rd2_value_d   = rd_view[rd2_num];
    assign rd1_pending_d = pend_view[rd1_num];
    assign rd2_pending_d = pend_view[rd2_num];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GP; i++) begin
                gp_q[i] <= '0;
            end
            sp_q          <= RESET_SP;
            pc_q          <= RESET_PC;
            flags_q       <= '0;
            pend_q        <= '0;
            rd1_value_q   <= '0;
            rd2_value_q   <= '0;
            rd1_pending_q <= 1'b0;
            rd2_pending_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GP; i++) begin
                gp_q[i] <= gp_d[i];
            end
            sp_q          <= sp_d;
            pc_q          <= pc_d;
            flags_q       <= flags_d;
            pend_q        <= pend_d;
            rd1_value_q   <= rd1_value_d;
            rd2_value_q   <= rd2_value_d;
            rd1_pending_q <= rd1_pending_d;
            rd2_pending_q <= rd2_pending_d;
        end
    end

    assign rd1_value   = rd1_value_q;
    assign rd2_value   = rd2_value_q;
    assign rd1_pending = rd1_pending_q;
    assign rd2_pending = rd2_pending_q;
    assign pc_value    = pc_q;
    assign flags_out   = flags_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding and one non-forwarding instance share stimulus;
// expectations are queued when a step is driven and compared after the following clock edge.
module tb_regfile_mp;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int FW = 8;

    localparam int A_RD1 = 0, A_RD2 = 1, A_P1 = 2, A_P2 = 3, A_PC = 4, A_FL = 5;
    localparam int B_OFS = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] rd1_num, rd2_num, wr1_num, wr2_num, reserve_num;
    logic          wr1_en, wr2_en, fetch_we, pc_inc, sp_push, sp_pop, reserve_en;
    logic [DW-1:0] wr1_value, wr2_value, fetch_value;
    logic [FW-1:0] flags_we, flags_in;

    logic [DW-1:0] a_rd1_value, a_rd2_value, a_pc_value;
    logic          a_rd1_pending, a_rd2_pending;
    logic [FW-1:0] a_flags_out;
    logic [DW-1:0] b_rd1_value, b_rd2_value, b_pc_value;
    logic          b_rd1_pending, b_rd2_pending;
    logic [FW-1:0] b_flags_out;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W(DW), .NUM_GP(8), .FLAG_W(FW), .BYPASS(1'b1), .PC_STEP(16'd1),
        .RESET_PC(16'h0100), .RESET_SP(16'hFFF0)
    ) u_byp (
        .clk(clk), .rst_n(rst_n),
        .rd1_num(rd1_num), .rd2_num(rd2_num),
        .rd1_value(a_rd1_value), .rd2_value(a_rd2_value),
        .rd1_pending(a_rd1_pending), .rd2_pending(a_rd2_pending),
        .wr1_en(wr1_en), .wr2_en(wr2_en), .wr1_num(wr1_num), .wr2_num(wr2_num),
        .wr1_value(wr1_value), .wr2_value(wr2_value),
        .fetch_we(fetch_we), .fetch_value(fetch_value), .pc_inc(pc_inc),
        .pc_value(a_pc_value), .sp_push(sp_push), .sp_pop(sp_pop),
        .flags_we(flags_we), .flags_in(flags_in), .flags_out(a_flags_out),
        .reserve_en(reserve_en), .reserve_num(reserve_num)
    );

    regfile_mp #(
        .DATA_W(DW), .NUM_GP(8), .FLAG_W(FW), .BYPASS(1'b0), .PC_STEP(16'd1),
        .RESET_PC(16'h0100), .RESET_SP(16'hFFF0)
    ) u_nob (
        .clk(clk), .rst_n(rst_n),
        .rd1_num(rd1_num), .rd2_num(rd2_num),
        .rd1_value(b_rd1_value), .rd2_value(b_rd2_value),
        .rd1_pending(b_rd1_pending), .rd2_pending(b_rd2_pending),
        .wr1_en(wr1_en), .wr2_en(wr2_en), .wr1_num(wr1_num), .wr2_num(wr2_num),
        .wr1_value(wr1_value), .wr2_value(wr2_value),
        .fetch_we(fetch_we), .fetch_value(fetch_value), .pc_inc(pc_inc),
        .pc_value(b_pc_value), .sp_push(sp_push), .sp_pop(sp_pop),
        .flags_we(flags_we), .flags_in(flags_in), .flags_out(b_flags_out),
        .reserve_en(reserve_en), .reserve_num(reserve_num)
    );

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            A_RD1:         return a_rd1_value;
            A_RD2:         return a_rd2_value;
            A_P1:          return {15'd0, a_rd1_pending};
            A_P2:          return {15'd0, a_rd2_pending};
            A_PC:          return a_pc_value;
            A_FL:          return {8'd0, a_flags_out};
            B_OFS + A_RD1: return b_rd1_value;
            B_OFS + A_RD2: return b_rd2_value;
            B_OFS + A_P1:  return {15'd0, b_rd1_pending};
            B_OFS + A_P2:  return {15'd0, b_rd2_pending};
            B_OFS + A_PC:  return b_pc_value;
            B_OFS + A_FL:  return {8'd0, b_flags_out};
            default:       return 16'hXXXX;
        endcase
    endfunction

    // Expected value for the forwarding instance (va) and the non-forwarding one (vb).
    task automatic expect2(input string tag, input int sel, input logic [15:0] va,
                           input logic [15:0] vb);
        sb_q.push_back('{tag: {tag, "_byp"}, sel: sel, val: va});
        sb_q.push_back('{tag: {tag, "_nob"}, sel: sel + B_OFS, val: vb});
    endtask

    task automatic idle();
        rst_n       = 1'b1;
        rd1_num     = '0;  rd2_num   = '0;
        wr1_en      = 1'b0; wr1_num  = '0; wr1_value = '0;
        wr2_en      = 1'b0; wr2_num  = '0; wr2_value = '0;
        fetch_we    = 1'b0; fetch_value = '0; pc_inc = 1'b0;
        sp_push     = 1'b0; sp_pop   = 1'b0;
        flags_we    = '0;  flags_in  = '0;
        reserve_en  = 1'b0; reserve_num = '0;
    endtask

    task automatic step();
        exp_t        e;
        logic [15:0] obs;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            n_chk++;
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
        idle();
    endtask

    initial begin
        idle();
        // reset with traffic that must all be discarded
        rst_n = 1'b0;
        wr1_en = 1'b1; wr1_num = 4'd3; wr1_value = 16'hAAAA;
        reserve_en = 1'b1; reserve_num = 4'd4;
        fetch_we = 1'b1; fetch_value = 16'h5555; sp_push = 1'b1;
        flags_we = 8'hFF; flags_in = 8'hFF;
        rd1_num = 4'd10; rd2_num = 4'd9;
        expect2("rst_rd1", A_RD1, 16'h0000, 16'h0000);
        expect2("rst_p1", A_P1, 16'h0000, 16'h0000);
        expect2("rst_pc", A_PC, 16'h0100, 16'h0100);
        expect2("rst_fl", A_FL, 16'h0000, 16'h0000);
        step();
        rd1_num = 4'd10; rd2_num = 4'd9;
        expect2("rst_pc_rd", A_RD1, 16'h0100, 16'h0100);
        expect2("rst_sp_rd", A_RD2, 16'hFFF0, 16'hFFF0);
        step();
        rd1_num = 4'd3; rd2_num = 4'd4;
        expect2("rst_gp", A_RD1, 16'h0000, 16'h0000);
        expect2("rst_pend", A_P2, 16'h0000, 16'h0000);
        step();
        // write collision on GP[2]
        wr1_en = 1'b1; wr1_num = 4'd3; wr1_value = 16'h1111;
        wr2_en = 1'b1; wr2_num = 4'd3; wr2_value = 16'h2222;
        rd1_num = 4'd3;
        expect2("coll_fwd", A_RD1, 16'h2222, 16'h0000);
        step();
        wr1_en = 1'b1; wr1_num = 4'd1; wr1_value = 16'hBEEF;
        rd1_num = 4'd1; rd2_num = 4'd3;
        expect2("bypass_same", A_RD1, 16'hBEEF, 16'h0000);
        expect2("coll_commit", A_RD2, 16'h2222, 16'h2222);
        step();
        rd1_num = 4'd1;
        expect2("bypass_next", A_RD1, 16'hBEEF, 16'hBEEF);
        step();
        // PC priority and wrap
        fetch_we = 1'b1; fetch_value = 16'h0010;
        expect2("pc_fetch", A_PC, 16'h0010, 16'h0010);
        step();
        pc_inc = 1'b1; fetch_we = 1'b1; fetch_value = 16'h0400;
        expect2("pc_fetch_over_inc", A_PC, 16'h0400, 16'h0400);
        step();
        fetch_we = 1'b1; fetch_value = 16'hFFFF;
        expect2("pc_ffff", A_PC, 16'hFFFF, 16'hFFFF);
        step();
        pc_inc = 1'b1;
        expect2("pc_wrap", A_PC, 16'h0000, 16'h0000);
        step();
        wr1_en = 1'b1; wr1_num = 4'd10; wr1_value = 16'h1234;
        fetch_we = 1'b1; fetch_value = 16'h7777; pc_inc = 1'b1; rd1_num = 4'd10;
        expect2("pc_wr_over_fetch", A_PC, 16'h1234, 16'h1234);
        expect2("pc_wr_rd", A_RD1, 16'h1234, 16'h0000);
        step();
        wr1_en = 1'b1; wr1_num = 4'd10; wr1_value = 16'h1111;
        wr2_en = 1'b1; wr2_num = 4'd10; wr2_value = 16'h2222; rd1_num = 4'd10;
        expect2("pc_wr2_wins", A_PC, 16'h2222, 16'h2222);
        expect2("pc_wr2_rd", A_RD1, 16'h2222, 16'h1234);
        step();
        // SP
        wr2_en = 1'b1; wr2_num = 4'd9; wr2_value = 16'h0000; sp_push = 1'b1; rd2_num = 4'd9;
        expect2("sp_wr_over_push", A_RD2, 16'h0000, 16'hFFF0);
        step();
        sp_push = 1'b1; rd2_num = 4'd9;
        expect2("sp_push_rd_old", A_RD2, 16'h0000, 16'h0000);
        step();
        sp_push = 1'b1; sp_pop = 1'b1; rd2_num = 4'd9;
        expect2("sp_push_wrap", A_RD2, 16'hFFFF, 16'hFFFF);
        step();
        sp_pop = 1'b1; rd2_num = 4'd9;
        expect2("sp_pushpop_hold", A_RD2, 16'hFFFF, 16'hFFFF);
        step();
        // flags
        rd2_num = 4'd9; flags_we = 8'hFF; flags_in = 8'hFF;
        expect2("sp_pop_wrap", A_RD2, 16'h0000, 16'h0000);
        expect2("fl_all", A_FL, 16'h00FF, 16'h00FF);
        step();
        flags_we = 8'h0F; flags_in = 8'h00;
        expect2("fl_low_clr", A_FL, 16'h00F0, 16'h00F0);
        step();
        flags_we = 8'h81; flags_in = 8'h01;
        expect2("fl_mixed", A_FL, 16'h0071, 16'h0071);
        step();
        // scoreboard
        reserve_en = 1'b1; reserve_num = 4'd5; rd1_num = 4'd5;
        expect2("pend_res_same", A_P1, 16'h0001, 16'h0000);
        step();
        rd1_num = 4'd5;
        expect2("pend_res_next", A_P1, 16'h0001, 16'h0001);
        step();
        wr1_en = 1'b1; wr1_num = 4'd5; wr1_value = 16'h0055;
        reserve_en = 1'b1; reserve_num = 4'd5; rd1_num = 4'd5;
        expect2("pend_wr_res", A_P1, 16'h0001, 16'h0001);
        expect2("pend_wr_res_val", A_RD1, 16'h0055, 16'h0000);
        step();
        rd1_num = 4'd5;
        expect2("pend_kept", A_P1, 16'h0001, 16'h0001);
        expect2("pend_kept_val", A_RD1, 16'h0055, 16'h0055);
        step();
        wr2_en = 1'b1; wr2_num = 4'd5; wr2_value = 16'h0066; rd1_num = 4'd5;
        expect2("pend_clr_same", A_P1, 16'h0000, 16'h0001);
        expect2("pend_clr_val", A_RD1, 16'h0066, 16'h0055);
        step();
        rd1_num = 4'd5;
        expect2("pend_clr_next", A_P1, 16'h0000, 16'h0000);
        step();
        // register 0 and unmapped numbers
        reserve_en = 1'b1; reserve_num = 4'd0;
        wr1_en = 1'b1; wr1_num = 4'd0; wr1_value = 16'hDEAD;
        expect2("zero_rd_same", A_RD1, 16'h0000, 16'h0000);
        expect2("zero_pend_same", A_P1, 16'h0000, 16'h0000);
        step();
        expect2("zero_rd", A_RD1, 16'h0000, 16'h0000);
        expect2("zero_pend", A_P1, 16'h0000, 16'h0000);
        step();
        reserve_en = 1'b1; reserve_num = 4'd12;
        wr1_en = 1'b1; wr1_num = 4'd12; wr1_value = 16'hDEAD; rd1_num = 4'd12;
        expect2("unmap_rd_same", A_RD1, 16'h0000, 16'h0000);
        expect2("unmap_pend_same", A_P1, 16'h0000, 16'h0000);
        step();
        rd1_num = 4'd12;
        expect2("unmap_rd", A_RD1, 16'h0000, 16'h0000);
        expect2("unmap_pend", A_P1, 16'h0000, 16'h0000);
        step();
        reserve_en = 1'b1; reserve_num = 4'd9; rd2_num = 4'd9;
        expect2("pend_sp_same", A_P2, 16'h0001, 16'h0000);
        step();
        rd2_num = 4'd9;
        expect2("pend_sp_next", A_P2, 16'h0001, 16'h0001);
        step();
        // reset mid-operation discards the write
        rst_n = 1'b0; wr1_en = 1'b1; wr1_num = 4'd1; wr1_value = 16'h9999; rd1_num = 4'd1;
        expect2("mid_rst_rd", A_RD1, 16'h0000, 16'h0000);
        expect2("mid_rst_pc", A_PC, 16'h0100, 16'h0100);
        step();
        rd1_num = 4'd1; rd2_num = 4'd9;
        expect2("mid_rst_gp", A_RD1, 16'h0000, 16'h0000);
        expect2("mid_rst_sp", A_RD2, 16'hFFF0, 16'hFFF0);
        expect2("mid_rst_pend", A_P2, 16'h0000, 16'h0000);
        expect2("mid_rst_fl", A_FL, 16'h0000, 16'h0000);
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
